ifetch_queue: RTL and testbench

- Consumer side of the program counter: takes the current PC and issues it as a read on the instruction-memory port.
- Buffers returned instructions, tagged with their PC, in a small queue for decode.
- Back-pressures the PC through pc_stall and flushes all wrong-path state on branch redirect.
- Sits between the program counter and the decode stage of the MIPS pipeline.

---
 rtl/ifetch_queue_pkg.sv | 15 +
 rtl/ifq_fifo.sv | 77 +++++++
 rtl/ifetch_queue.sv | 102 ++++++++++
 tb/tb_ifetch_queue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared sizing and FSM encoding for the instruction fetch queue.
// Replaces the old define.v macros with package constants.
package ifetch_queue_pkg;

  localparam int IFQ_DEPTH = 4;
  localparam int IFQ_AW    = 32;
  localparam int IFQ_DW    = 32;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_WAIT = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Small flop-based FIFO holding {pc, instr} entries for decode.
// Flush clears pointers and count; head is read straight from storage by rptr.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push = push && !flush;
    // Popping an empty queue is a no-op rather than an underflow.
    do_pop  = pop && !flush && (count_q != '0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (do_push) mem_d[wptr_q] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign dout  = mem_q[rptr_q];
  assign count = count_q;

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && count_q == (PW+1)'(DEPTH))
  );

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: issues the PC to instruction memory, one request in flight,
// and queues returned instructions tagged with their PC for decode.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW,
  parameter int DW    = IFQ_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  input  logic          redirect,
  output logic          pc_stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          dec_valid,
  output logic [DW-1:0] dec_instr,
  output logic [AW-1:0] dec_pc,
  input  logic          dec_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_e       state_q, state_d;
  logic [AW-1:0]    req_pc_q, req_pc_d;
  logic [CW-1:0]    count;
  logic [AW+DW-1:0] head;
  logic             room;
  logic             accept;
  logic             push;

  // Requests only issue with a free slot, so the in-flight return always fits.
  assign room = (count != CW'(DEPTH));

  always_comb begin
    imem_req  = rst_n && (state_q == IFQ_IDLE) && !redirect && room;
    imem_addr = pc;
    accept    = imem_req && imem_gnt;
    pc_stall  = !accept;
    push      = 1'b0;
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    case (state_q)
      IFQ_IDLE: begin
        if (accept) begin
          state_d  = IFQ_WAIT;
          req_pc_d = pc;
        end
      end
      IFQ_WAIT: begin
        if (imem_rvalid) begin
          push    = !redirect;
          state_d = IFQ_IDLE;
        end else if (redirect) begin
          state_d = IFQ_DROP;
        end
      end
      IFQ_DROP: begin
        // The wrong-path return still has to arrive before a new request.
        if (imem_rvalid) state_d = IFQ_IDLE;
      end
      default: state_d = IFQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IFQ_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .din   ({req_pc_q, imem_rdata}),
    .pop   (dec_ready),
    .dout  (head),
    .count (count)
  );

  assign dec_valid = (count != '0);
  assign dec_pc    = head[AW+DW-1:DW];
  assign dec_instr = head[DW-1:0];

  a_no_stray_rvalid: assert property (
    @(posedge clk) disable iff (!rst_n) !(state_q == IFQ_IDLE && imem_rvalid)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: queue-level reference model checked every
// cycle, plus hand-computed literal checks at key points of each scenario.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic        redirect = 1'b0;
  logic [31:0] target = 32'h0;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  ifetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .redirect    (redirect),
    .pc_stall    (pc_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready)
  );

  always #10 clk = ~clk;

  // Program counter: loads the target on redirect, advances when not stalled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pc <= 32'h0;
    else if (redirect)      pc <= target;
    else if (!pc_stall)     pc <= pc + 32'd4;
  end

  // Instruction memory: returns one word rsp_lat cycles after each grant.
  logic        rsp_pend = 1'b0;
  int          rsp_cnt = 0;
  int          rsp_lat = 1;
  logic [31:0] rsp_addr = 32'h0;
  logic        rsp_fixed = 1'b1;
  logic [31:0] rsp_word = 32'h2001_0005;

  always @(posedge clk) begin
    if (imem_rvalid)   rsp_pend <= 1'b0;
    else if (rsp_pend) rsp_cnt <= rsp_cnt - 1;
    if (imem_req && imem_gnt) begin
      rsp_pend <= 1'b1;
      rsp_cnt  <= rsp_lat;
      rsp_addr <= imem_addr;
    end
  end

  assign imem_rvalid = rsp_pend && (rsp_cnt == 1);
  assign imem_rdata  = rsp_fixed ? rsp_word : (32'hA000_0000 | rsp_addr);

  // Reference model: a queue of tagged entries plus "fetch in flight" and
  // "in-flight fetch is wrong-path" flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy = 1'b0;
  bit          m_poison = 1'b0;
  logic [31:0] m_pc = 32'h0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_busy   = 1'b0;
        m_poison = 1'b0;
      end else begin
        bit take;
        take = !m_busy && !redirect && (mq.size() < 4) && imem_gnt;
        if (redirect) mq.delete();
        else if (dec_ready && mq.size() > 0) void'(mq.pop_front());
        if (m_busy && imem_rvalid) begin
          if (!m_poison && !redirect) mq.push_back('{m_pc, imem_rdata});
          m_busy = 1'b0;
        end else if (m_busy && redirect) begin
          m_poison = 1'b1;
        end
        if (take) begin
          m_busy   = 1'b1;
          m_poison = 1'b0;
          m_pc     = pc;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst pc_stall", {31'b0, pc_stall}, 32'd1);
        chk("rst dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst dec_pc", dec_pc, 32'h0);
        chk("rst dec_instr", dec_instr, 32'h0);
      end else begin
        logic exp_req;
        exp_req = !m_busy && !redirect && (mq.size() < 4);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        chk("pc_stall", {31'b0, pc_stall}, {31'b0, !(exp_req && imem_gnt)});
        chk("imem_addr", imem_addr, pc);
        chk("dec_valid", {31'b0, dec_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
          chk("dec_pc", dec_pc, mq[0].pc);
          chk("dec_instr", dec_instr, mq[0].instr);
        end
        if (dec_valid && dec_instr == 32'hDEAD_BEEF) begin
          chk("wrong-path data on dec_instr", dec_instr, 32'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset then steady fetch
    ticks(2);
    #2;
    chk("t1 reset req", {31'b0, imem_req}, 32'd0);
    chk("t1 reset stall", {31'b0, pc_stall}, 32'd1);
    tick();
    rst_n = 1'b1; imem_gnt = 1'b1; dec_ready = 1'b1; rsp_lat = 1;
    #2;
    chk("t1 first req", {31'b0, imem_req}, 32'd1);
    chk("t1 first addr", imem_addr, 32'h0);
    chk("t1 stall c1", {31'b0, pc_stall}, 32'd0);
    tick(); #2;
    chk("t1 stall c2", {31'b0, pc_stall}, 32'd1);
    chk("t1 no valid yet", {31'b0, dec_valid}, 32'd0);
    tick(); #2;
    chk("t1 dec_valid", {31'b0, dec_valid}, 32'd1);
    chk("t1 dec_pc", dec_pc, 32'h0);
    chk("t1 dec_instr", dec_instr, 32'h2001_0005);
    chk("t1 stall c3", {31'b0, pc_stall}, 32'd0);
    ticks(5);

    // 2. Back-pressure to full
    tick();
    redirect = 1'b1; target = 32'h0; dec_ready = 1'b0; rsp_fixed = 1'b0;
    tick();
    redirect = 1'b0;
    ticks(10);
    #2;
    chk("t2 model size", mq.size(), 32'd4);
    chk("t2 model tail pc", mq[mq.size()-1].pc, 32'h0C);
    chk("t2 full head pc", dec_pc, 32'h00);
    chk("t2 full head instr", dec_instr, 32'hA000_0000);
    chk("t2 full no req", {31'b0, imem_req}, 32'd0);
    chk("t2 full stall", {31'b0, pc_stall}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick(); #2;
      chk("t2 full holds no req", {31'b0, imem_req}, 32'd0);
      chk("t2 full holds head", dec_pc, 32'h00);
    end
    tick();
    dec_ready = 1'b1;
    #2;
    chk("t2 pop cycle no req", {31'b0, imem_req}, 32'd0);
    tick();
    dec_ready = 1'b0;
    #2;
    chk("t2 after pop head", dec_pc, 32'h04);
    chk("t2 after pop req", {31'b0, imem_req}, 32'd1);
    chk("t2 after pop addr", imem_addr, 32'h10);
    ticks(2);

    // 3. Redirect during WAIT
    tick();
    redirect = 1'b1; target = 32'h10; imem_gnt = 1'b0;
    tick();
    redirect = 1'b0; imem_gnt = 1'b1; rsp_lat = 3;
    rsp_fixed = 1'b1; rsp_word = 32'hDEAD_BEEF;
    #2;
    chk("t3 req at 0x10", imem_addr, 32'h10);
    chk("t3 empty", {31'b0, dec_valid}, 32'd0);
    tick();
    redirect = 1'b1; target = 32'h40; imem_gnt = 1'b0;
    tick();
    redirect = 1'b0; imem_gnt = 1'b1;
    #2;
    chk("t3 drop no req", {31'b0, imem_req}, 32'd0);
    chk("t3 pc target", imem_addr, 32'h40);
    tick(); #2;
    chk("t3 drop rvalid no req", {31'b0, imem_req}, 32'd0);
    tick();
    rsp_fixed = 1'b0; rsp_lat = 1;
    #2;
    chk("t3 req after drop", {31'b0, imem_req}, 32'd1);
    chk("t3 addr after drop", imem_addr, 32'h40);
    chk("t3 queue empty", {31'b0, dec_valid}, 32'd0);

    // 4. Redirect coincident with rvalid and pop, two entries queued
    ticks(4);
    tick();
    redirect = 1'b1; target = 32'h80; dec_ready = 1'b1;
    #2;
    chk("t4 no req on redirect", {31'b0, imem_req}, 32'd0);
    chk("t4 two queued head", dec_pc, 32'h40);
    tick();
    redirect = 1'b0; dec_ready = 1'b0; imem_gnt = 1'b0;
    #2;
    chk("t4 flushed", {31'b0, dec_valid}, 32'd0);
    chk("t4 req at target", imem_addr, 32'h80);

    // 5. Slow memory
    for (int i = 0; i < 2; i++) begin
      tick(); #2;
      chk("t5 req held", {31'b0, imem_req}, 32'd1);
      chk("t5 addr held", imem_addr, 32'h80);
      chk("t5 stall until gnt", {31'b0, pc_stall}, 32'd1);
    end
    tick();
    imem_gnt = 1'b1; rsp_lat = 5;
    #2;
    chk("t5 granted", {31'b0, pc_stall}, 32'd0);
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      chk("t5 waiting no req", {31'b0, imem_req}, 32'd0);
    end
    tick();
    imem_gnt = 1'b1; rsp_lat = 3;
    #2;
    chk("t5 single entry pc", dec_pc, 32'h80);
    chk("t5 single entry instr", dec_instr, 32'hA000_0080);

    // 6. Async reset mid-WAIT
    tick();
    imem_gnt = 1'b0;
    #2;
    chk("t6 entry before reset", {31'b0, dec_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #2;
    chk("t6 async dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("t6 async req", {31'b0, imem_req}, 32'd0);
    chk("t6 async stall", {31'b0, pc_stall}, 32'd1);
    ticks(3);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("t6 late rvalid ignored", {31'b0, dec_valid}, 32'd0);
      tick();
    end

    // Closing steady stream with 2-cycle memory latency
    imem_gnt = 1'b1; dec_ready = 1'b1; rsp_lat = 2;
    ticks(10);
    imem_gnt = 1'b0;
    ticks(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
